// File: rtl/axi_lite_arb2_pkg.sv
// ============================================================================
// Module : axi_lite_arb2_pkg
// Brief  : Shared widths, arbiter state encoding and a next-state helper for
//          the two-master AXI-lite arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_arb2_pkg;

  // Default bus widths of the instruction/data SRAM path
  localparam int unsigned INST_ADDR_BUS  = 32;
  localparam int unsigned MEM_DATA_BUS   = 32;
  localparam int unsigned MEM_STRB_BUS   = 8;
  localparam int unsigned RRESP_DATA_BUS = 2;

  // Arbiter grant states
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_G0_RD = 2'd1,
    ARB_G1_RD = 2'd2,
    ARB_G1_WR = 2'd3
  } arb_state_e;

  // The LSU presents read and write on separate channels; a read wins when
  // both are raised together.
  function automatic arb_state_e arb_m1_target(input logic i_ar);
    return i_ar ? ARB_G1_RD : ARB_G1_WR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_rr2_pick.sv
// ============================================================================
// Module : arb_rr2_pick
// Brief  : Two-requester round-robin pick. The requester that was not granted
//          last wins a tie.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr2_pick
  import axi_lite_arb2_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_gnt0,
  output logic o_gnt1
);

  // last_grant = 1 means master 1 went last, so master 0 wins a tie
  always_comb begin
    o_gnt0 = i_req0 & (~i_req1 | i_last_grant);
    o_gnt1 = i_req1 & (~i_req0 | ~i_last_grant);
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_arb2.sv
// ============================================================================
// Module : axi_lite_arb2
// Brief  : Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite
//          arbiter. One transaction owns the slave from grant until its
//          response handshake; response channels are pure pass-through.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_arb2
  import axi_lite_arb2_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_BUS,
  parameter int unsigned DATA_W = MEM_DATA_BUS,
  parameter int unsigned STRB_W = MEM_STRB_BUS,
  parameter int unsigned RESP_W = RRESP_DATA_BUS
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (IFU) read
  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [RESP_W-1:0] o_m0_rresp,
  output logic              o_m0_rvalid,
  input  logic              i_m0_rready,
  // master 1 (LSU) read
  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [RESP_W-1:0] o_m1_rresp,
  output logic              o_m1_rvalid,
  input  logic              i_m1_rready,
  // master 1 (LSU) write
  input  logic [ADDR_W-1:0] i_m1_awaddr,
  input  logic              i_m1_awvalid,
  output logic              o_m1_awready,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [STRB_W-1:0] i_m1_wstrb,
  input  logic              i_m1_wvalid,
  output logic              o_m1_wready,
  output logic [RESP_W-1:0] o_m1_bresp,
  output logic              o_m1_bvalid,
  input  logic              i_m1_bready,
  // slave (SRAM)
  output logic [ADDR_W-1:0] o_s_araddr,
  output logic              o_s_arvalid,
  input  logic              i_s_arready,
  input  logic [DATA_W-1:0] i_s_rdata,
  input  logic [RESP_W-1:0] i_s_rresp,
  input  logic              i_s_rvalid,
  output logic              o_s_rready,
  output logic [ADDR_W-1:0] o_s_awaddr,
  output logic              o_s_awvalid,
  input  logic              i_s_awready,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic [STRB_W-1:0] o_s_wstrb,
  output logic              o_s_wvalid,
  input  logic              i_s_wready,
  input  logic [RESP_W-1:0] i_s_bresp,
  input  logic              i_s_bvalid,
  output logic              o_s_bready
);

  arb_state_e        r_state;
  logic              r_last_grant;
  logic              r_addr_done;
  logic [ADDR_W-1:0] r_awaddr;

  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_exit;
  logic w_addr_hs;

  assign w_req0 = i_m0_arvalid;
  assign w_req1 = i_m1_arvalid | i_m1_awvalid;

  arb_rr2_pick u_pick (
    .i_req0       (w_req0),
    .i_req1       (w_req1),
    .i_last_grant (r_last_grant),
    .o_gnt0       (w_gnt0),
    .o_gnt1       (w_gnt1)
  );

  // Address-channel handshake and response-complete (exit) for the owner
  always_comb begin
    w_exit    = 1'b0;
    w_addr_hs = 1'b0;
    case (r_state)
      ARB_G0_RD: begin
        w_exit    = i_s_rvalid & i_m0_rready;
        w_addr_hs = o_s_arvalid & i_s_arready;
      end
      ARB_G1_RD: begin
        w_exit    = i_s_rvalid & i_m1_rready;
        w_addr_hs = o_s_arvalid & i_s_arready;
      end
      ARB_G1_WR: begin
        w_exit    = i_s_bvalid & i_m1_bready;
        w_addr_hs = o_s_awvalid & i_s_awready;
      end
      default: ;
    endcase
  end

  // Grant FSM, round-robin history and the captured write address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= 1'b1;
      r_addr_done  <= 1'b0;
      r_awaddr     <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt0) begin
            r_state      <= ARB_G0_RD;
            r_last_grant <= 1'b0;
          end else if (w_gnt1) begin
            r_state      <= arb_m1_target(i_m1_arvalid);
            r_last_grant <= 1'b1;
          end
        end
        default: begin
          if (w_exit) begin
            r_state     <= ARB_IDLE;
            r_addr_done <= 1'b0;
            r_awaddr    <= '0;
          end else if (w_addr_hs) begin
            r_addr_done <= 1'b1;
            if (r_state == ARB_G1_WR) begin
              r_awaddr <= i_m1_awaddr;
            end
          end
        end
      endcase
    end
  end

  // Route the owning master to the slave; everything else is held at zero.
  // The address valid is gated after its handshake so a late-dropping master
  // cannot issue a second address inside one grant.
  always_comb begin
    o_m0_arready = 1'b0;
    o_m0_rdata   = '0;
    o_m0_rresp   = '0;
    o_m0_rvalid  = 1'b0;
    o_m1_arready = 1'b0;
    o_m1_rdata   = '0;
    o_m1_rresp   = '0;
    o_m1_rvalid  = 1'b0;
    o_m1_awready = 1'b0;
    o_m1_wready  = 1'b0;
    o_m1_bresp   = '0;
    o_m1_bvalid  = 1'b0;
    o_s_araddr   = '0;
    o_s_arvalid  = 1'b0;
    o_s_rready   = 1'b0;
    o_s_awaddr   = '0;
    o_s_awvalid  = 1'b0;
    o_s_wdata    = '0;
    o_s_wstrb    = '0;
    o_s_wvalid   = 1'b0;
    o_s_bready   = 1'b0;
    case (r_state)
      ARB_G0_RD: begin
        o_s_araddr   = i_m0_araddr;
        o_s_arvalid  = i_m0_arvalid & ~r_addr_done;
        o_m0_arready = i_s_arready & ~r_addr_done;
        o_m0_rdata   = i_s_rdata;
        o_m0_rresp   = i_s_rresp;
        o_m0_rvalid  = i_s_rvalid;
        o_s_rready   = i_m0_rready;
      end
      ARB_G1_RD: begin
        o_s_araddr   = i_m1_araddr;
        o_s_arvalid  = i_m1_arvalid & ~r_addr_done;
        o_m1_arready = i_s_arready & ~r_addr_done;
        o_m1_rdata   = i_s_rdata;
        o_m1_rresp   = i_s_rresp;
        o_m1_rvalid  = i_s_rvalid;
        o_s_rready   = i_m1_rready;
      end
      ARB_G1_WR: begin
        // The slave samples awaddr at W time, so hold the captured copy
        o_s_awaddr   = r_addr_done ? r_awaddr : i_m1_awaddr;
        o_s_awvalid  = i_m1_awvalid & ~r_addr_done;
        o_m1_awready = i_s_awready & ~r_addr_done;
        o_s_wdata    = i_m1_wdata;
        o_s_wstrb    = i_m1_wstrb;
        o_s_wvalid   = i_m1_wvalid;
        o_m1_wready  = i_s_wready;
        o_m1_bresp   = i_s_bresp;
        o_m1_bvalid  = i_s_bvalid;
        o_s_bready   = i_m1_bready;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_arb2.sv
// ============================================================================
// Module : tb_axi_lite_arb2
// Brief  : Scoreboard bench for axi_lite_arb2 with a simple SRAM-like slave.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_arb2;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
  logic        m0_arvalid, m1_arvalid, m1_awvalid, m1_wvalid;
  logic        m0_rready, m1_rready, m1_bready;
  logic [7:0]  m1_wstrb;
  logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid;
  logic        m1_awready, m1_wready, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp;

  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [7:0]  s_wstrb;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]  s_rresp, s_bresp;

  axi_lite_arb2 dut (
    .clk(clk), .rst(rst),
    .i_m0_araddr(m0_araddr), .i_m0_arvalid(m0_arvalid), .o_m0_arready(m0_arready),
    .o_m0_rdata(m0_rdata), .o_m0_rresp(m0_rresp), .o_m0_rvalid(m0_rvalid), .i_m0_rready(m0_rready),
    .i_m1_araddr(m1_araddr), .i_m1_arvalid(m1_arvalid), .o_m1_arready(m1_arready),
    .o_m1_rdata(m1_rdata), .o_m1_rresp(m1_rresp), .o_m1_rvalid(m1_rvalid), .i_m1_rready(m1_rready),
    .i_m1_awaddr(m1_awaddr), .i_m1_awvalid(m1_awvalid), .o_m1_awready(m1_awready),
    .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb), .i_m1_wvalid(m1_wvalid), .o_m1_wready(m1_wready),
    .o_m1_bresp(m1_bresp), .o_m1_bvalid(m1_bvalid), .i_m1_bready(m1_bready),
    .o_s_araddr(s_araddr), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
    .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
    .o_s_awaddr(s_awaddr), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
    .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wvalid(s_wvalid), .i_s_wready(s_wready),
    .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready)
  );

  // ---------------- slave model: 1-cycle read, AW before W, then B --------
  logic sl_rd_busy, sl_aw_got;
  assign s_arready = ~sl_rd_busy;
  assign s_awready = ~sl_aw_got & ~s_bvalid;
  assign s_wready  = sl_aw_got;

  function automatic logic [31:0] sl_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1234_5678);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sl_rd_busy <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
      sl_aw_got  <= 1'b0; s_bvalid <= 1'b0; s_bresp <= '0;
    end else begin
      if (s_arvalid && s_arready) begin
        sl_rd_busy <= 1'b1;
        s_rvalid   <= 1'b1;
        s_rdata    <= sl_data(s_araddr);
        s_rresp    <= (s_araddr[31:28] == 4'h9) ? 2'b10 : 2'b00;
      end else if (s_rvalid && s_rready) begin
        sl_rd_busy <= 1'b0;
        s_rvalid   <= 1'b0;
        s_rdata    <= '0;
      end
      if (s_awvalid && s_awready) sl_aw_got <= 1'b1;
      if (s_wvalid && s_wready) begin
        sl_aw_got <= 1'b0;
        s_bvalid  <= 1'b1;
        s_bresp   <= (s_awaddr[31:28] == 4'h9) ? 2'b10 : 2'b00;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ---------------------------------------------
  typedef struct packed { logic wr; logic [31:0] addr; } addr_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rd_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [7:0] strb; } wr_t;

  addr_t      exp_addr_q[$];
  rd_t        exp_r0_q[$];
  rd_t        exp_r1_q[$];
  wr_t        exp_w_q[$];
  logic [1:0] exp_b_q[$];

  int   n_vec  = 0;
  int   n_fail = 0;
  logic chk_m1_quiet = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got an unexpected handshake, expected none", name);
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got timeout after %0d cycles, expected handshake", name, TMO);
  endtask

  // Monitor: compare every handshake the DUT presents against the queues
  always @(negedge clk) begin
    if (rst) begin
      addr_t a; rd_t r; wr_t w; logic [1:0] b;
      check("ar_aw_exclusive", {79'd0, s_arvalid & s_awvalid}, 80'd0);
      if (s_arvalid && s_arready) begin
        if (exp_addr_q.size() == 0) unexpected("slave_ar");
        else begin a = exp_addr_q.pop_front(); check("slave_ar", {1'b0, s_araddr}, {a.wr, a.addr}); end
      end
      if (s_awvalid && s_awready) begin
        if (exp_addr_q.size() == 0) unexpected("slave_aw");
        else begin a = exp_addr_q.pop_front(); check("slave_aw", {1'b1, s_awaddr}, {a.wr, a.addr}); end
      end
      if (s_wvalid && s_wready) begin
        if (exp_w_q.size() == 0) unexpected("slave_w");
        else begin w = exp_w_q.pop_front(); check("slave_w", {s_awaddr, s_wdata, s_wstrb}, w); end
      end
      if (m0_rvalid && m0_rready) begin
        if (exp_r0_q.size() == 0) unexpected("m0_r");
        else begin r = exp_r0_q.pop_front(); check("m0_r", {m0_rdata, m0_rresp}, r); end
      end
      if (m1_rvalid && m1_rready) begin
        if (exp_r1_q.size() == 0) unexpected("m1_r");
        else begin r = exp_r1_q.pop_front(); check("m1_r", {m1_rdata, m1_rresp}, r); end
      end
      if (m1_bvalid && m1_bready) begin
        if (exp_b_q.size() == 0) unexpected("m1_b");
        else begin b = exp_b_q.pop_front(); check("m1_b", {78'd0, m1_bresp}, {78'd0, b}); end
      end
      if (chk_m1_quiet)
        check("m1_quiet", {75'd0, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 80'd0);
    end
  end

  // ---------------- master drivers -----------------------------------------
  task automatic m0_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    bit hs = 0;
    exp_r0_q.push_back({d, r});
    m0_araddr = a; m0_arvalid = 1'b1;
    for (int i = 0; i < TMO && !hs; i++) begin
      @(negedge clk); hs = m0_arvalid && m0_arready; @(posedge clk); #1;
    end
    m0_arvalid = 1'b0; m0_araddr = '0;
    if (!hs) timeout("m0_ar");
    hs = 0;
    for (int i = 0; i < TMO && !hs; i++) begin
      @(negedge clk); hs = m0_rvalid && m0_rready; @(posedge clk); #1;
    end
    if (!hs) timeout("m0_r_wait");
  endtask

  task automatic m1_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    bit hs = 0;
    exp_r1_q.push_back({d, r});
    m1_araddr = a; m1_arvalid = 1'b1;
    for (int i = 0; i < TMO && !hs; i++) begin
      @(negedge clk); hs = m1_arvalid && m1_arready; @(posedge clk); #1;
    end
    m1_arvalid = 1'b0; m1_araddr = '0;
    if (!hs) timeout("m1_ar");
    hs = 0;
    for (int i = 0; i < TMO && !hs; i++) begin
      @(negedge clk); hs = m1_rvalid && m1_rready; @(posedge clk); #1;
    end
    if (!hs) timeout("m1_r_wait");
  endtask

  // Master drops awaddr to 0 right after its AW handshake
  task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                          input logic [1:0] br, input bit wait_b);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, hs = 0;
    exp_w_q.push_back({a, d, s});
    if (wait_b) exp_b_q.push_back(br);
    m1_awaddr = a; m1_awvalid = 1'b1;
    m1_wdata = d; m1_wstrb = s; m1_wvalid = 1'b1;
    for (int i = 0; i < TMO && !(aw_done && w_done); i++) begin
      @(negedge clk);
      aw_hs = m1_awvalid && m1_awready;
      w_hs  = m1_wvalid && m1_wready;
      @(posedge clk); #1;
      if (aw_hs) begin m1_awvalid = 1'b0; m1_awaddr = '0; aw_done = 1; end
      if (w_hs)  begin m1_wvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0; w_done = 1; end
    end
    if (!(aw_done && w_done)) timeout("m1_aw_w");
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    if (wait_b) begin
      for (int i = 0; i < TMO && !hs; i++) begin
        @(negedge clk); hs = m1_bvalid && m1_bready; @(posedge clk); #1;
      end
      if (!hs) timeout("m1_b_wait");
    end
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    bit seen;
    m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
    m1_awaddr = '0; m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0;
    m1_wvalid = 1'b0; m1_bready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {68'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready,
           m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 80'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Round robin from reset: m0 first, then strict alternation
    exp_addr_q.push_back({1'b0, 32'h8000_0000});
    exp_addr_q.push_back({1'b0, 32'h8000_0100});
    exp_addr_q.push_back({1'b0, 32'h8000_0004});
    exp_addr_q.push_back({1'b0, 32'h9000_0008});
    fork
      begin
        m0_read(32'h8000_0000, 32'h0000_0413, 2'b00);
        m0_read(32'h8000_0004, 32'h9234_567C, 2'b00);
      end
      begin
        m1_read(32'h8000_0100, 32'h9234_5778, 2'b00);
        m1_read(32'h9000_0008, 32'h8234_5670, 2'b10);
      end
    join

    // m0 read alone: one-cycle grant latency, m1 quiet, IDLE after R
    repeat (2) @(posedge clk); #1;
    chk_m1_quiet = 1'b1;
    exp_addr_q.push_back({1'b0, 32'h8000_0000});
    fork
      m0_read(32'h8000_0000, 32'h0000_0413, 2'b00);
      begin
        @(negedge clk); check("grant_latency_idle", {79'd0, s_arvalid}, 80'd0);
        @(negedge clk); check("grant_latency_gnt",  {79'd0, s_arvalid}, 80'd1);
      end
    join
    @(negedge clk);
    check("idle_after_r", {78'd0, s_rready, m0_rvalid}, 80'd0);
    chk_m1_quiet = 1'b0;
    @(posedge clk); #1;

    // m1 write: slave must see the captured awaddr at W; B once
    exp_addr_q.push_back({1'b1, 32'h8000_1000});
    m1_write(32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 2'b00, 1);
    @(negedge clk);
    check("b_single_pulse", {79'd0, m1_bvalid}, 80'd0);
    @(posedge clk); #1;

    // m1 read and write together: read first, then write
    exp_addr_q.push_back({1'b0, 32'h8000_0200});
    exp_addr_q.push_back({1'b1, 32'h9000_0010});
    fork
      m1_read(32'h8000_0200, 32'h9234_5478, 2'b00);
      m1_write(32'h9000_0010, 32'h1234_5678, 8'hF0, 2'b10, 1);
    join

    // m0 stalls R for 5 cycles: grant held, m1 read locked out
    repeat (2) @(posedge clk); #1;
    m0_rready = 1'b0;
    exp_addr_q.push_back({1'b0, 32'h8000_0010});
    exp_addr_q.push_back({1'b0, 32'h8000_0300});
    fork
      m0_read(32'h8000_0010, 32'h9234_5668, 2'b00);
      begin
        seen = 0;
        for (int i = 0; i < TMO && !seen; i++) begin
          @(negedge clk); seen = m0_rvalid;
        end
        if (!seen) timeout("m0_rvalid_stall");
        @(posedge clk); #1;
        fork
          m1_read(32'h8000_0300, 32'h9234_5578, 2'b00);
          begin
            for (int i = 0; i < 5; i++) begin
              @(negedge clk);
              check("stall_hold", {77'd0, m1_arready, s_arvalid, m0_rvalid}, 80'd1);
            end
            @(posedge clk); #1 m0_rready = 1'b1;
          end
        join
      end
    join

    // Reset while in G1_WR with B pending
    repeat (2) @(posedge clk); #1;
    m1_bready = 1'b0;
    exp_addr_q.push_back({1'b1, 32'h8000_1040});
    m1_write(32'h8000_1040, 32'hCAFE_F00D, 8'h03, 2'b00, 0);
    seen = 0;
    for (int i = 0; i < TMO && !seen; i++) begin
      @(negedge clk); seen = m1_bvalid;
    end
    check("b_pending_before_rst", {79'd0, seen}, 80'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_ctrl",
          {68'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready,
           m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 80'd0);
    check("midrst_data", {s_awaddr, s_araddr, 16'd0}, 80'd0);
    repeat (2) @(posedge clk); #1;
    m1_bready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_addr_q.push_back({1'b0, 32'h8000_0000});
    m0_read(32'h8000_0000, 32'h0000_0413, 2'b00);

    repeat (2) @(negedge clk);
    check("queues_drained",
          {48'd0, exp_addr_q.size() + exp_r0_q.size() + exp_r1_q.size()
                  + exp_w_q.size() + exp_b_q.size()}, 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
